// File: rtl/sdram_image_writer_pkg.sv
// Shared image-layout types for the SDRAM image writer.
// Planes interleave per word: background in the low byte, mask in the high byte.
package sdram_image_writer_pkg;

    localparam int unsigned PLANE_BYTES = 1555200;

    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 16;
    localparam int BYTES_W = 22;

    typedef enum logic {
        BACKGROUND = 1'b0,
        MASK       = 1'b1
    } plane_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2
    } wr_state_t;

    typedef struct packed {
        plane_t              plane;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } wr_word_t;

    localparam int WORD_W = $bits(wr_word_t);

    function automatic logic [1:0] lane_of(plane_t p);
        return (p == MASK) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_image_writer_fifo.sv
// Small synchronous word FIFO between the download stream and the SDRAM writer.
// Depth must be a power of two so the pointers wrap naturally.
module write_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_image_writer.sv
// Splits downloaded 16-bit words into byte-lane SDRAM writes for the
// interleaved background/mask image layout.
module sdram_image_writer #(
    parameter int unsigned PLANE_BYTES = sdram_image_writer_pkg::PLANE_BYTES,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_data,
    output logic [1:0]  sd_byte_en,
    output logic        sd_wr_req,
    input  logic        sd_wr_ack,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [21:0] bytes_written
);

    import sdram_image_writer_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_AT   = CW'(FIFO_DEPTH - 1);
    localparam logic [25:0]   PLANE_END = 26'(PLANE_BYTES);
    localparam logic [25:0]   IMAGE_END = 26'(2 * PLANE_BYTES);

    logic [25:0]       offset;
    logic              in_bg;
    logic              in_mask;
    logic              in_range;
    wr_word_t          in_word;
    wr_word_t          head;
    logic [WORD_W-1:0] head_bits;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;

    wr_state_t         state;
    logic [7:0]        hold_hi;

    logic              dl_q;
    logic              armed;
    logic              dl_rise;
    logic              acked;
    logic [21:0]       bytes_base;

    assign offset   = {1'b0, ioctl_addr};
    assign in_bg    = offset < PLANE_END;
    assign in_mask  = !in_bg && (offset < IMAGE_END);
    assign in_range = in_bg || in_mask;

    always_comb begin
        in_word       = '0;
        in_word.plane = in_bg ? BACKGROUND : MASK;
        in_word.addr  = in_bg ? ioctl_addr : 25'(offset - PLANE_END);
        in_word.data  = ioctl_dout;
    end

    assign push = ioctl_wr && in_range && !fifo_full;
    assign drop = ioctl_wr && (!in_range || fifo_full);
    assign head = wr_word_t'(head_bits);

    // One spare slot absorbs a strobe the source already had in flight.
    assign ioctl_wait = fifo_count >= WAIT_AT;

    write_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (in_word),
        .pop     (pop),
        .rd_data (head_bits),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = !fifo_empty;
            REQ_HI:  pop = sd_wr_ack && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sd_wr_req  <= 1'b0;
            sd_addr    <= '0;
            sd_data    <= '0;
            sd_byte_en <= '0;
            hold_hi    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        sd_addr    <= head.addr;
                        sd_data    <= {2{head.data[7:0]}};
                        sd_byte_en <= lane_of(head.plane);
                        hold_hi    <= head.data[15:8];
                        sd_wr_req  <= 1'b1;
                        state      <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (sd_wr_ack) begin
                        sd_addr <= sd_addr + 25'd1;
                        sd_data <= {2{hold_hi}};
                        state   <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (sd_wr_ack) begin
                        if (pop) begin
                            sd_addr    <= head.addr;
                            sd_data    <= {2{head.data[7:0]}};
                            sd_byte_en <= lane_of(head.plane);
                            hold_hi    <= head.data[15:8];
                            state      <= REQ_LO;
                        end else begin
                            sd_wr_req <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    sd_wr_req <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign busy       = !fifo_empty || (state != IDLE);
    assign dl_rise    = ioctl_download && !dl_q;
    assign acked      = sd_wr_req && sd_wr_ack;
    assign bytes_base = dl_rise ? '0 : bytes_written;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_q          <= 1'b0;
            armed         <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            bytes_written <= '0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise) begin
                armed    <= 1'b1;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else if (armed && !ioctl_download && !busy) begin
                armed <= 1'b0;
                done  <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (acked && (bytes_base != 22'h3FFFFF)) begin
                bytes_written <= bytes_base + 22'd1;
            end else begin
                bytes_written <= bytes_base;
            end
        end
    end

endmodule

// File: tb/tb_sdram_image_writer.sv
// Bench for sdram_image_writer: directed cases plus randomized traffic
// against a queue-based model of the expected SDRAM write sequence.
module tb_sdram_image_writer;

    localparam int unsigned P = 1555200;
    localparam int DEPTH = 4;

    typedef logic [42:0] wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic [24:0] sd_addr;
    logic [15:0] sd_data;
    logic [1:0]  sd_byte_en;
    logic        sd_wr_req;
    logic        sd_wr_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [21:0] bytes_written;

    always #5 clk = ~clk;

    sdram_image_writer #(
        .PLANE_BYTES (P),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .sd_addr        (sd_addr),
        .sd_data        (sd_data),
        .sd_byte_en     (sd_byte_en),
        .sd_wr_req      (sd_wr_req),
        .sd_wr_ack      (sd_wr_ack),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .bytes_written  (bytes_written)
    );

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    wr_t log_q[$];
    int  n_acked = 0;
    bit  ovf_m = 0;
    bit  dl_prev = 0;
    bit  drop_next = 0;
    bit  chk_en = 0;
    int  ack_mode = 0;
    int  ack_delay = 2;
    bit  ack_noise = 0;
    int  hold_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected writes for one stream word, straight from the plane rules.
    function automatic void model_word(input logic [24:0] a, input logic [15:0] d);
        int unsigned o;
        int unsigned b;
        logic [1:0]  be;
        o = a;
        if (o >= 2 * P) begin
            ovf_m = 1;
            return;
        end
        if (o < P) begin
            b = o;
            be = 2'b01;
        end else begin
            b = o - P;
            be = 2'b10;
        end
        exp_q.push_back({25'(b), {2{d[7:0]}}, be});
        exp_q.push_back({25'(b + 1), {2{d[15:8]}}, be});
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            exp_q.delete();
            n_acked = 0;
            ovf_m = 0;
            dl_prev = 0;
        end else begin
            if (ioctl_download && !dl_prev) begin
                ovf_m = 0;
                n_acked = 0;
            end
            dl_prev = ioctl_download;
            if (ioctl_wr) begin
                if (drop_next) begin
                    ovf_m = 1;
                    drop_next = 0;
                end else begin
                    model_word(ioctl_addr, ioctl_dout);
                end
            end
        end
    end

    // SDRAM responder and per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            sd_wr_ack = 0;
            hold_cnt = 0;
        end else if (chk_en) begin
            chk("bytes_written", bytes_written, n_acked);
            chk("overflow", overflow, ovf_m);
            chk("busy", busy, exp_q.size() != 0);
            if (done) chk("done_while_pending", exp_q.size(), 0);
            if (sd_wr_req) begin
                hold_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", sd_wr_req, 0);
                    sd_wr_ack = 0;
                end else begin
                    chk("sd_payload", {sd_addr, sd_data, sd_byte_en}, exp_q[0]);
                    case (ack_mode)
                        1:       sd_wr_ack = (hold_cnt >= ack_delay);
                        2:       sd_wr_ack = ($urandom_range(0, 1) == 1);
                        default: sd_wr_ack = 0;
                    endcase
                    if (sd_wr_ack) begin
                        log_q.push_back({sd_addr, sd_data, sd_byte_en});
                        void'(exp_q.pop_front());
                        n_acked++;
                        hold_cnt = 0;
                    end
                end
            end else begin
                hold_cnt = 0;
                sd_wr_ack = ack_noise ? ($urandom_range(0, 1) == 1) : 1'b0;
            end
        end
    end

    task automatic strobe(input int unsigned a, input logic [15:0] d, input bit honor);
        int g = 0;
        if (honor) begin
            while (ioctl_wait && g < 1000) begin
                @(negedge clk);
                g++;
            end
            if (g >= 1000) chk("wait_timeout", ioctl_wait, 0);
        end
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        ioctl_wr = 1;
        @(negedge clk);
        ioctl_wr = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, n < 3000, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned o;
        repeat (3) @(negedge clk);
        chk("rst_req", sd_wr_req, 0);
        chk("rst_payload", {sd_addr, sd_data, sd_byte_en}, 0);
        chk("rst_status", {busy, done, overflow, ioctl_wait}, 0);
        chk("rst_bytes", bytes_written, 0);
        reset_n = 1;
        @(negedge clk);
        chk_en = 1;

        // download 1: background word, mask word, out-of-range word
        ioctl_download = 1;
        @(negedge clk);
        ack_mode = 1;
        ack_delay = 2;
        log_q.delete();
        strobe(0, 16'hBBAA, 1);
        wait_idle("t1");
        chk("t1_nwr", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t1_w0", log_q[0], {25'd0, 16'hAAAA, 2'b01});
            chk("t1_w1", log_q[1], {25'd1, 16'hBBBB, 2'b01});
        end
        chk("t1_bytes", bytes_written, 2);

        log_q.delete();
        strobe(P, 16'h2211, 1);
        wait_idle("t2");
        chk("t2_nwr", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t2_w0", log_q[0], {25'd0, 16'h1111, 2'b10});
            chk("t2_w1", log_q[1], {25'd1, 16'h2222, 2'b10});
        end

        log_q.delete();
        strobe(2 * P, 16'h5555, 1);
        repeat (4) @(negedge clk);
        chk("t4_ovf", overflow, 1);
        chk("t4_bytes", bytes_written, 4);
        chk("t4_nwr", log_q.size(), 0);

        ioctl_download = 0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("d1_done", done, 1);

        // download 2: stall the SDRAM side and overrun the FIFO
        ioctl_download = 1;
        @(negedge clk);
        chk("d2_done_clr", done, 0);
        chk("d2_ovf_clr", overflow, 0);
        chk("d2_bytes_clr", bytes_written, 0);
        ack_mode = 0;
        log_q.delete();
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) drop_next = 1;
            strobe(100 + 4 * k, 16'($urandom), 0);
            if (k == 3) chk("t3_wait_k3", ioctl_wait, 0);
            if (k == 4) chk("t3_wait_k4", ioctl_wait, 1);
            if (k == 5) chk("t3_ovf_k5", overflow, 0);
            if (k == 6) chk("t3_ovf_k6", overflow, 1);
        end
        ack_mode = 2;
        wait_idle("t3");
        chk("t3_nwr", log_q.size(), 10);

        // download 3: done only after the last of 16 acks
        ioctl_download = 0;
        repeat (2) @(negedge clk);
        ioctl_download = 1;
        @(negedge clk);
        chk("d3_done_clr", done, 0);
        log_q.delete();
        for (int k = 0; k < 8; k++) begin
            strobe(2 * k, 16'($urandom), 1);
        end
        ioctl_download = 0;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_done", done, 1);
        chk("t5_bytes", bytes_written, 16);
        chk("t5_nwr", log_q.size(), 16);
        ioctl_download = 1;
        @(negedge clk);
        chk("t5_rise_done", done, 0);
        chk("t5_rise_bytes", bytes_written, 0);

        // randomized traffic with plane boundaries and noisy ack
        ack_noise = 1;
        strobe(P - 2, 16'h0102, 1);
        strobe(2 * P - 2, 16'h0304, 1);
        strobe(2 * P, 16'h0506, 1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) o = 2 * P + 2 * $urandom_range(0, 1000);
            else o = 2 * $urandom_range(0, P - 1);
            strobe(o, 16'($urandom), 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("rand");

        // reset while a request is outstanding
        ack_noise = 0;
        ack_mode = 0;
        strobe(10, 16'h7788, 1);
        strobe(20, 16'h99AA, 1);
        n = 0;
        while (!sd_wr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_req_seen", sd_wr_req, 1);
        @(posedge clk);
        #2;
        reset_n = 0;
        #1;
        chk("t6_req_clr", sd_wr_req, 0);
        chk("t6_busy_clr", busy, 0);
        chk("t6_bytes_clr", bytes_written, 0);
        @(negedge clk);
        reset_n = 1;
        ack_mode = 2;
        ack_noise = 1;
        repeat (20) @(negedge clk);
        chk("t6_no_replay", sd_wr_req, 0);
        chk("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
